// File: rtl/pulse_wave_synth_if.sv
// Control and sample bundle between the square-channel logic and the
// pulse-wave synthesis stage; master drives controls, slave returns samples.
interface pulse_wave_synth_if;
    logic        I_TICK;
    logic        I_TRIGGER;
    logic [10:0] I_FREQUENCY;
    logic [1:0]  I_DUTY_CYCLE;
    logic        I_WAVEFORM_EN;
    logic [3:0]  I_VOLUME;
    logic        I_STROBE;
    logic [3:0]  O_SAMPLE;
    logic        O_SAMPLE_VALID;
    logic [2:0]  O_PHASE;

    modport master (
        output I_TICK, I_TRIGGER, I_FREQUENCY, I_DUTY_CYCLE,
        output I_WAVEFORM_EN, I_VOLUME, I_STROBE,
        input  O_SAMPLE, O_SAMPLE_VALID, O_PHASE
    );

    modport slave (
        input  I_TICK, I_TRIGGER, I_FREQUENCY, I_DUTY_CYCLE,
        input  I_WAVEFORM_EN, I_VOLUME, I_STROBE,
        output O_SAMPLE, O_SAMPLE_VALID, O_PHASE
    );
endinterface

// File: rtl/pulse_wave_synth.sv
// Square channel 1/2 pulse generator: 11-bit frequency timer, 8-step
// duty sequencer and a registered 4-bit sample per frame strobe.
module pulse_wave_synth #(
    parameter int TIMER_W = 11
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    pulse_wave_synth_if.slave   bus
);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         step_q, step_d;
    logic [3:0]         sample_q, sample_d;
    logic               valid_q, valid_d;
    logic [7:0]         pattern;
    logic [3:0]         level;

    // Timer/step update: trigger wins over tick; frequency is only
    // latched at trigger or reload so mid-period writes never glitch.
    always_comb begin
        timer_d = timer_q;
        step_d  = step_q;
        if (bus.I_TRIGGER) begin
            timer_d = bus.I_FREQUENCY;
            step_d  = 3'd0;
        end else if (bus.I_TICK && bus.I_WAVEFORM_EN) begin
            if (timer_q == {TIMER_W{1'b1}}) begin
                timer_d = bus.I_FREQUENCY;
                step_d  = step_q + 3'd1;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end
    end

    // Duty waveform, bit n is the level of step n.
    always_comb begin
        pattern = 8'h00;
        unique case (bus.I_DUTY_CYCLE)
            2'b00: pattern = 8'b1000_0000;
            2'b01: pattern = 8'b1000_0001;
            2'b10: pattern = 8'b1110_0001;
            2'b11: pattern = 8'b0111_1110;
            default: pattern = 8'h00;
        endcase
    end

    // Output level from the registered step, gated by channel enable.
    always_comb begin
        level = 4'd0;
        if (bus.I_WAVEFORM_EN && pattern[step_q]) begin
            level = bus.I_VOLUME;
        end
    end

    // Sample capture: every strobe yields one valid pulse.
    always_comb begin
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (bus.I_STROBE) begin
            sample_d = level;
            valid_d  = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            timer_q  <= '0;
            step_q   <= 3'd0;
            sample_q <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            step_q   <= step_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.O_SAMPLE       = sample_q;
    assign bus.O_SAMPLE_VALID = valid_q;
    assign bus.O_PHASE        = step_q;

endmodule

// File: tb/tb_pulse_wave_synth.sv
// Scoreboard bench for pulse_wave_synth: directed stimulus pushes
// expected samples, a negedge monitor pops and compares them.
module tb_pulse_wave_synth;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    logic [3:0] expq[$];

    pulse_wave_synth_if bus ();

    pulse_wave_synth dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected duty sweep samples at volume 9, steps 0..7.
    logic [3:0] duty_exp [4][8] = '{
        '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9},
        '{4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9},
        '{4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd9, 4'd9},
        '{4'd0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0}
    };

    // Period test at freq 2046, duty 10, vol 15: two samples per step.
    logic [3:0] period_exp [16] = '{
        4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
        4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15
    };

    // Monitor: compare every valid sample against the scoreboard.
    always @(negedge clk) begin
        if (bus.O_SAMPLE_VALID) begin
            checks++;
            if (expq.size() == 0) begin
                $display("FAIL sample_unexpected: got %0d, none expected",
                         bus.O_SAMPLE);
            end else begin
                logic [3:0] e;
                e = expq.pop_front();
                if (bus.O_SAMPLE === e) passes++;
                else $display("FAIL sample: got %0d, expected %0d",
                              bus.O_SAMPLE, e);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // One clock of stimulus; strobe pushes its expected sample.
    task automatic drive(input logic tk, input logic tr, input logic sb,
                         input logic [3:0] exp);
        bus.I_TICK    = tk;
        bus.I_TRIGGER = tr;
        bus.I_STROBE  = sb;
        if (sb) expq.push_back(exp);
        @(posedge clk);
        #1;
        bus.I_TICK    = 1'b0;
        bus.I_TRIGGER = 1'b0;
        bus.I_STROBE  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus.I_TICK        = 1'b0;
        bus.I_TRIGGER     = 1'b0;
        bus.I_FREQUENCY   = 11'd2047;
        bus.I_DUTY_CYCLE  = 2'b11;
        bus.I_WAVEFORM_EN = 1'b1;
        bus.I_VOLUME      = 4'd15;
        bus.I_STROBE      = 1'b0;

        // Reset state.
        #3;
        chk("rst_phase", {1'b0, bus.O_PHASE}, 4'd0);
        chk("rst_sample", bus.O_SAMPLE, 4'd0);
        chk("rst_valid", {3'b0, bus.O_SAMPLE_VALID}, 4'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Run a little, capture a nonzero sample, then reset mid-cycle.
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        ticks(3);
        chk("pre_rst_phase", {1'b0, bus.O_PHASE}, 4'd3);
        drive(1'b0, 1'b0, 1'b1, 4'd15);
        bus.I_TICK = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_phase", {1'b0, bus.O_PHASE}, 4'd0);
        chk("async_rst_sample", bus.O_SAMPLE, 4'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2047; i++) begin
            @(posedge clk);
        end
        #1;
        chk("rst_2047_ticks", {1'b0, bus.O_PHASE}, 4'd0);
        @(posedge clk);
        #1;
        chk("rst_2048_ticks", {1'b0, bus.O_PHASE}, 4'd1);
        bus.I_TICK = 1'b0;

        // Period accuracy at freq 2046, duty 50%.
        bus.I_FREQUENCY  = 11'd2046;
        bus.I_DUTY_CYCLE = 2'b10;
        bus.I_VOLUME     = 4'd15;
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, period_exp[i]);
            if (i == 4) chk("period_phase5t", {1'b0, bus.O_PHASE}, 4'd2);
        end
        chk("period_wrap", {1'b0, bus.O_PHASE}, 4'd0);

        // Duty sweep, one step per tick.
        bus.I_FREQUENCY = 11'd2047;
        bus.I_VOLUME    = 4'd9;
        for (int d = 0; d < 4; d++) begin
            bus.I_DUTY_CYCLE = 2'(d);
            drive(1'b0, 1'b1, 1'b0, 4'd0);
            for (int s = 0; s < 8; s++) begin
                drive(1'b1, 1'b0, 1'b1, duty_exp[d][s]);
            end
        end

        // Frequency change mid-step takes effect at reload.
        bus.I_FREQUENCY = 11'd2040;
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        ticks(3);
        bus.I_FREQUENCY = 11'd2047;
        ticks(4);
        chk("glitch_7t", {1'b0, bus.O_PHASE}, 4'd0);
        ticks(1);
        chk("glitch_8t", {1'b0, bus.O_PHASE}, 4'd1);
        ticks(1);
        chk("glitch_9t", {1'b0, bus.O_PHASE}, 4'd2);
        ticks(1);
        chk("glitch_10t", {1'b0, bus.O_PHASE}, 4'd3);

        // Trigger beats tick in the same cycle.
        bus.I_FREQUENCY = 11'd2045;
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        chk("prio_trig", {1'b0, bus.O_PHASE}, 4'd0);
        ticks(2);
        chk("prio_2t", {1'b0, bus.O_PHASE}, 4'd0);
        ticks(1);
        chk("prio_3t", {1'b0, bus.O_PHASE}, 4'd1);

        // Disable holds phase and silences output.
        bus.I_DUTY_CYCLE = 2'b11;
        bus.I_VOLUME     = 4'd15;
        drive(1'b0, 1'b0, 1'b1, 4'd15);
        bus.I_WAVEFORM_EN = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, (i % 25) == 0, 4'd0);
        end
        chk("hold_phase", {1'b0, bus.O_PHASE}, 4'd1);
        bus.I_WAVEFORM_EN = 1'b1;
        ticks(2);
        chk("resume_2t", {1'b0, bus.O_PHASE}, 4'd1);
        ticks(1);
        chk("resume_3t", {1'b0, bus.O_PHASE}, 4'd2);
        drive(1'b0, 1'b0, 1'b1, 4'd15);

        // Trigger while disabled still restarts.
        bus.I_WAVEFORM_EN = 1'b0;
        bus.I_FREQUENCY   = 11'd2047;
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        chk("trig_disabled", {1'b0, bus.O_PHASE}, 4'd0);
        bus.I_WAVEFORM_EN = 1'b1;

        // Strobe coinciding with a tick sees the pre-update step.
        bus.I_DUTY_CYCLE = 2'b00;
        drive(1'b1, 1'b0, 1'b1, 4'd0);
        chk("coinc_phase", {1'b0, bus.O_PHASE}, 4'd1);
        drive(1'b0, 1'b0, 1'b1, 4'd0);
        ticks(6);
        chk("coinc_step7", {1'b0, bus.O_PHASE}, 4'd7);
        drive(1'b0, 1'b0, 1'b1, 4'd15);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL sb_drain: got %0d pending, expected 0",
                      expq.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
